// File: rtl/pattern_writer.sv
// rtl/pattern_writer.sv - Wishbone master that writes a test pattern over a frame buffer
//
// Ports:
//   sys_clk, sys_rst_n        : clock, asynchronous active-low reset
//   enable                    : frame generation request
//   cyc, stb, we, adr, dat_ms : Wishbone master write cycle
//   sel, cti, bte             : constant byte enables / classic cycle type
//   ack, err, rty             : slave responses (ack wins over err/rty)
//   frame_done                : one-cycle pulse after the last pixel of a frame is acked
module pattern_writer #(
    parameter int          HDISP     = 800,
    parameter int          VDISP     = 480,
    parameter logic [31:0] BASE_ADR  = 32'h0,
    parameter int          BURST_LEN = 64
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        enable,
    output logic        cyc,
    output logic        stb,
    output logic        we,
    output logic [31:0] adr,
    output logic [31:0] dat_ms,
    output logic [3:0]  sel,
    output logic [2:0]  cti,
    output logic [1:0]  bte,
    input  logic        ack,
    input  logic        err,
    input  logic        rty,
    output logic        frame_done
);

    localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int BW = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [1:0]    rst_sync;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [7:0]    fcnt;
    logic [BW-1:0] burst_cnt;
    logic          beat;
    logic          x_last;
    logic          y_last;
    logic          burst_last;
    logic          frame_end;
    logic [31:0]   pix_idx;
    logic [7:0]    x8;
    logic [7:0]    y8;

    // Reset assertion is immediate, but release must pass two flops before
    // the FSM may leave IDLE.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign beat       = (state == WRITE) && ack;
    assign x_last     = (x == XW'(HDISP - 1));
    assign y_last     = (y == YW'(VDISP - 1));
    assign burst_last = (burst_cnt == BW'(BURST_LEN - 1));
    assign frame_end  = beat && x_last && y_last;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cyc        = 1'b0;
        stb        = 1'b0;
        case (state)
            IDLE: begin
                if (enable && rst_sync[1]) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                cyc = 1'b1;
                stb = 1'b1;
                if (ack) begin
                    if (frame_end || burst_last) begin
                        state_next = PAUSE;
                    end
                end else if (err || rty) begin
                    // Error or retry: keep the same pixel on the bus and reissue it.
                    state_next = WRITE;
                end
            end
            PAUSE: begin
                state_next = enable ? WRITE : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            x          <= '0;
            y          <= '0;
            fcnt       <= 8'd0;
            burst_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            // Counting only inside WRITE means every entry to WRITE starts at zero.
            if (state != WRITE) begin
                burst_cnt <= '0;
            end else if (beat) begin
                burst_cnt <= burst_cnt + BW'(1);
            end
            if (beat) begin
                if (x_last) begin
                    x <= '0;
                    if (y_last) begin
                        y    <= '0;
                        fcnt <= fcnt + 8'd1;
                    end else begin
                        y <= y + YW'(1);
                    end
                end else begin
                    x <= x + XW'(1);
                end
            end
        end
    end

    // Address and data follow the pixel counters directly, so they are stable
    // for as long as the current write is not acked and track reset instantly.
    assign pix_idx = 32'(y) * 32'(HDISP) + 32'(x);
    assign adr     = BASE_ADR + (pix_idx << 2);
    assign x8      = 8'(x);
    assign y8      = 8'(y);
    assign dat_ms  = {fcnt, x8, y8, x8 ^ y8};

    assign we  = stb;
    assign sel = 4'hF;
    assign cti = 3'b000;
    assign bte = 2'b00;

endmodule
